// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled stepper driving up/down count, chase and bounce patterns.
// State table (bounce direction): DIR_LEFT | pattern shifts toward MSB ; DIR_RIGHT | pattern shifts toward LSB
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap
);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [WIDTH-1:0] led_q;
    logic             tick_q;
    logic             wrap_q;
    dir_e             dir_q;

    logic             step;
    logic             onehot;
    logic [WIDTH-1:0] led_d;
    dir_e             dir_d;
    logic             wrap_d;

    // >= rather than == so shrinking div mid-period steps immediately instead of wrapping cnt
    assign step   = en && (cnt_q >= div);
    assign onehot = (led_q != '0) && ((led_q & (led_q - ONE)) == '0);

    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        case (mode)
            2'b00: begin
                led_d  = led_q + ONE;
                wrap_d = (led_q == ALL_ONES);
            end
            2'b01: begin
                led_d  = led_q - ONE;
                wrap_d = (led_q == '0);
            end
            2'b10: begin
                if (led_q == '0) begin
                    led_d = ONE;
                end else begin
                    led_d  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    wrap_d = led_q[WIDTH-1];
                end
            end
            default: begin
                if (!onehot) begin
                    led_d = ONE;
                    dir_d = DIR_LEFT;
                end else if (dir_q == DIR_LEFT) begin
                    led_d = led_q << 1;
                    if (led_d[WIDTH-1]) begin
                        dir_d  = DIR_RIGHT;
                        wrap_d = 1'b1;
                    end
                end else begin
                    led_d = led_q >> 1;
                    if (led_d[0]) begin
                        dir_d  = DIR_LEFT;
                        wrap_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            led_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            dir_q  <= DIR_LEFT;
        end else if (load) begin
            cnt_q  <= '0;
            led_q  <= load_val;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            dir_q  <= DIR_LEFT;
        end else if (step) begin
            cnt_q  <= '0;
            led_q  <= led_d;
            tick_q <= 1'b1;
            wrap_q <= wrap_d;
            dir_q  <= dir_d;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (en) begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (WIDTH=8, DIV_W=16).
module tb_led_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic [1:0]  mode;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  led;
    logic        tick;
    logic        wrap;

    int n_tests = 0;
    int n_fail  = 0;

    led_pattern_gen #(.WIDTH(8), .DIV_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (div),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .led      (led),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; div = 16'd0; mode = 2'b00; load = 1'b1; load_val = 8'h77;
        cyc();
        cyc();
        n_tests++;
        if (led !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: led=%h tick=%b wrap=%b, want led=00 tick=0 wrap=0", led, tick, wrap);
        end
        load = 1'b0;
    endtask

    task automatic test_count_up();
        logic [7:0] exp_led;
        int bad_idle = 0;
        rst = 1'b1; en = 1'b1; div = 16'd3; mode = 2'b00; load = 1'b0;
        cyc();
        rst = 1'b0;
        for (int s = 1; s <= 256; s++) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                if (tick !== 1'b0 || wrap !== 1'b0) bad_idle++;
            end
            cyc();
            exp_led = 8'(s);
            n_tests++;
            if (tick !== 1'b1 || led !== exp_led || wrap !== (s == 256)) begin
                n_fail++;
                $display("FAIL up_step%0d: led=%h tick=%b wrap=%b, want led=%h tick=1 wrap=%b",
                         s, led, tick, wrap, exp_led, (s == 256));
            end
        end
        n_tests++;
        if (bad_idle != 0) begin
            n_fail++;
            $display("FAIL up_idle: %0d non-step cycles had tick/wrap set, want 0", bad_idle);
        end
    endtask

    task automatic test_count_down();
        load = 1'b1; load_val = 8'h00; mode = 2'b01; div = 16'd0; en = 1'b1;
        cyc();
        load = 1'b0;
        n_tests++;
        if (led !== 8'h00 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL down_load: led=%h tick=%b, want led=00 tick=0", led, tick);
        end
        cyc();
        n_tests++;
        if (led !== 8'hFF || tick !== 1'b1 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap: led=%h tick=%b wrap=%b, want FF 1 1", led, tick, wrap);
        end
        cyc();
        n_tests++;
        if (led !== 8'hFE || tick !== 1'b1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL down_next: led=%h tick=%b wrap=%b, want FE 1 0", led, tick, wrap);
        end
    endtask

    task automatic test_chase();
        logic [7:0] exp_led;
        logic       exp_wrap;
        load = 1'b1; load_val = 8'h00; mode = 2'b10; div = 16'd0; en = 1'b1;
        cyc();
        load = 1'b0;
        for (int s = 1; s <= 9; s++) begin
            cyc();
            exp_led  = 8'h01 << ((s - 1) % 8);
            exp_wrap = (s == 9);
            n_tests++;
            if (led !== exp_led || tick !== 1'b1 || wrap !== exp_wrap) begin
                n_fail++;
                $display("FAIL chase_step%0d: led=%h tick=%b wrap=%b, want %h 1 %b",
                         s, led, tick, wrap, exp_led, exp_wrap);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp_seq [16];
        logic       exp_wrap;
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        load = 1'b1; load_val = 8'h05; mode = 2'b11; div = 16'd0; en = 1'b1;
        cyc();
        load = 1'b0;
        for (int s = 0; s < 16; s++) begin
            cyc();
            exp_wrap = (s == 7) || (s == 14);
            n_tests++;
            if (led !== exp_seq[s] || tick !== 1'b1 || wrap !== exp_wrap) begin
                n_fail++;
                $display("FAIL bounce_step%0d: led=%h tick=%b wrap=%b, want %h 1 %b",
                         s, led, tick, wrap, exp_seq[s], exp_wrap);
            end
        end
    endtask

    task automatic test_div_change();
        int early_ticks = 0;
        load = 1'b1; load_val = 8'h00; mode = 2'b00; div = 16'd100; en = 1'b1;
        cyc();
        load = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (tick !== 1'b0) early_ticks++;
        end
        n_tests++;
        if (early_ticks != 0 || led !== 8'h00) begin
            n_fail++;
            $display("FAIL div_run50: ticks=%0d led=%h, want 0 ticks led=00", early_ticks, led);
        end
        div = 16'd10;
        cyc();
        n_tests++;
        if (tick !== 1'b1 || led !== 8'h01) begin
            n_fail++;
            $display("FAIL div_shrink: tick=%b led=%h, want 1 01", tick, led);
        end
        for (int k = 0; k < 10; k++) cyc();
        n_tests++;
        if (tick !== 1'b0 || led !== 8'h01) begin
            n_fail++;
            $display("FAIL div_gap: tick=%b led=%h, want 0 01", tick, led);
        end
        cyc();
        n_tests++;
        if (tick !== 1'b1 || led !== 8'h02) begin
            n_fail++;
            $display("FAIL div_period11: tick=%b led=%h, want 1 02", tick, led);
        end
        for (int k = 0; k < 3; k++) cyc();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_tests++;
            if (tick !== 1'b0 || wrap !== 1'b0 || led !== 8'h02) begin
                n_fail++;
                $display("FAIL en_freeze%0d: tick=%b wrap=%b led=%h, want 0 0 02", k, tick, wrap, led);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 7; k++) cyc();
        n_tests++;
        if (tick !== 1'b0 || led !== 8'h02) begin
            n_fail++;
            $display("FAIL en_resume_gap: tick=%b led=%h, want 0 02", tick, led);
        end
        cyc();
        n_tests++;
        if (tick !== 1'b1 || led !== 8'h03) begin
            n_fail++;
            $display("FAIL en_resume_step: tick=%b led=%h, want 1 03", tick, led);
        end
    endtask

    task automatic test_load_priority();
        mode = 2'b00; div = 16'd0; en = 1'b1; load = 1'b0;
        cyc();
        load = 1'b1; load_val = 8'hA5;
        cyc();
        n_tests++;
        if (led !== 8'hA5 || tick !== 1'b0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL load_vs_step: led=%h tick=%b wrap=%b, want A5 0 0", led, tick, wrap);
        end
        load = 1'b0; en = 1'b0;
        cyc();
        load = 1'b1; load_val = 8'h3C;
        cyc();
        n_tests++;
        if (led !== 8'h3C || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL load_while_disabled: led=%h tick=%b, want 3C 0", led, tick);
        end
        en = 1'b1; div = 16'd2; rst = 1'b1; load_val = 8'h99;
        cyc();
        n_tests++;
        if (led !== 8'h00 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_vs_load: led=%h tick=%b, want 00 0", led, tick);
        end
        rst = 1'b0; load = 1'b0;
        cyc();
        cyc();
        n_tests++;
        if (tick !== 1'b0 || led !== 8'h00) begin
            n_fail++;
            $display("FAIL post_rst_gap: tick=%b led=%h, want 0 00", tick, led);
        end
        cyc();
        n_tests++;
        if (tick !== 1'b1 || led !== 8'h01) begin
            n_fail++;
            $display("FAIL post_rst_step: tick=%b led=%h, want 1 01", tick, led);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div = 16'd0; mode = 2'b00; load = 1'b0; load_val = 8'h00;
        test_reset();
        test_count_up();
        test_count_down();
        test_chase();
        test_bounce();
        test_div_change();
        test_load_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
